mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the CPU data bus, beside the 1024×16 main memory. Decodes CPU writes to a data address, buffers bytes in a small FIFO, and serializes them as 8N1 on a single output pin. Exposes a readable status word with the same one-cycle read latency as main memory. Downstream consumer of the CPU's output-port writes; gives a program a real character output path on hardware.

## Interface
- CLK_DIV, 234, clock cycles per UART bit (≥2); 27 MHz / 115200 baud
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥2
- DATA_ADDR, 10'h001, write address for TX bytes
- STAT_ADDR, 10'h002, read/write address for status
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mem_addr  in  10  CPU bus address
- wr_data  in  16  CPU write data
- mem_wr  in  1  CPU write strobe; read implied when low
- rd_data  out  16  registered status read data
- rd_hit  out  1  registered; high when rd_data is valid for the bus read mux
- busy  out  1  FIFO non-empty or frame in progress
- uart_tx  out  1  serial line, idle high

## Operation
- Reset values: uart_tx=1, busy=0, rd_data=0, rd_hit=0, FIFO empty, overflow=0, FSM=IDLE.
- Reset asserted mid-frame: uart_tx returns to 1 immediately, FIFO flushed, partial frame abandoned.
- Write with mem_wr=1 and mem_addr=DATA_ADDR pushes wr_data[7:0]. wr_data[15:8] is ignored.
- Push is accepted when count<FIFO_DEPTH, or when a pop occurs on the same edge.
- Otherwise the byte is dropped and the sticky overflow flag is set.
- Write to STAT_ADDR with wr_data[2]=1 clears overflow. Other bits are ignored.
- If a clear and an overflowing push occur on the same edge, overflow ends set.
- Status word: bit0=busy, bit1=full (count==FIFO_DEPTH), bit2=overflow, bit3=empty, bits[15:4]=0.
- Read path:
  - Each edge with mem_wr=0 and mem_addr=STAT_ADDR loads rd_data with the status and sets rd_hit=1.
  - Any other edge sets rd_data=0 and rd_hit=0.
- FIFO count width: $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: uart_tx=1. When the FIFO is non-empty, pop into the shift register, go to START, load the baud counter with CLK_DIV-1.
  - START: uart_tx=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: uart_tx=shift[0] for CLK_DIV cycles per bit, LSB first. Shift right after each bit; after bit 7, go to STOP.
  - STOP: uart_tx=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START; else go to IDLE.
- The baud counter decrements each cycle. The state/bit advances on the cycle the counter is 0, and the counter reloads with CLK_DIV-1.
- uart_tx is driven from a register (glitch-free).

## Timing
- Write sampled at edge E0; FIFO non-empty after E0.
- At E1 the FSM pops and uart_tx falls. The start bit occupies E1 to E1+CLK_DIV.
- Frame length is exactly 10·CLK_DIV cycles.
- Back-to-back bytes: zero idle cycles between a stop bit and the next start bit.
- busy rises after E0. It falls on the edge ending the last stop bit with the FIFO empty.
- Status read: address at edge R0, rd_data/rd_hit valid after R0, one-cycle latency (matches main memory).
- The status reflects state before edge R0's updates.

## Test plan
- CLK_DIV=4, write 0x0041 to DATA_ADDR:
  - uart_tx low 4 cycles starting one cycle after the write.
  - Then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles.
  - busy high 41 cycles.
- Three consecutive writes 0x31,0x32,0x33 -> 120 contiguous frame cycles, no gap, correct bytes.
- FIFO_DEPTH=8, ten consecutive writes 0x00..0x09:
  - Byte 0 pops at E1; bytes 1–8 fill the FIFO; byte 9 is dropped.
  - Status reads 0x0007 (busy, full, overflow).
  - 0x00..0x08 are transmitted.
- Write 0x0004 to STAT_ADDR, then read STAT_ADDR:
  - overflow cleared; rd_hit=1 for exactly one cycle.
  - rd_data bit2=0; rd_data=0x0008 once the line is idle.
- Write 0xAB55 -> frame carries 0x55.
- Assert rst during the DATA state of a frame with 3 bytes queued:
  - uart_tx=1 immediately, busy=0, status 0x0008.
  - No further frames after reset release.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view shared by the UART transmitter and the bus master.
// The read return path (rd_data/rd_hit) feeds the CPU read mux beside main memory.
interface mmio_uart_tx_if;
    logic [9:0]  mem_addr;
    logic [15:0] wr_data;
    logic        mem_wr;
    logic [15:0] rd_data;
    logic        rd_hit;

    modport master (
        output mem_addr, wr_data, mem_wr,
        input  rd_data, rd_hit
    );

    modport slave (
        input  mem_addr, wr_data, mem_wr,
        output rd_data, rd_hit
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by CPU writes, registered
// status read port with main-memory latency, registered serial output.
module mmio_uart_tx #(
    parameter int unsigned CLK_DIV    = 234,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [9:0]  DATA_ADDR  = 10'h001,
    parameter logic [9:0]  STAT_ADDR  = 10'h002
) (
    input  logic           clk,
    input  logic           rst,
    mmio_uart_tx_if.slave  bus,
    output logic           busy,
    output logic           uart_tx
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [15:0]   rd_data_q, rd_data_d;
    logic          rd_hit_q, rd_hit_d;

    logic          push_req, push_ok, pop;
    logic          fifo_empty, fifo_full, ovf_clr;
    logic [15:0]   status;
    logic          unused_wr_hi;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign push_req   = bus.mem_wr && (bus.mem_addr == DATA_ADDR);
    assign ovf_clr    = bus.mem_wr && (bus.mem_addr == STAT_ADDR) && bus.wr_data[2];
    // A full FIFO still takes a byte when the transmitter frees a slot on the same edge.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign busy       = !fifo_empty || (state_q != S_IDLE);
    assign status     = {12'h000, fifo_empty, ovf_q, fifo_full, busy};
    assign unused_wr_hi = ^bus.wr_data[15:8];

    assign uart_tx     = tx_q;
    assign bus.rd_data = rd_data_q;
    assign bus.rd_hit  = rd_hit_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_q[rptr_q];
                    baud_d  = BAUD_RELOAD;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_q[rptr_q];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_ok) wptr_d = wptr_q + PW'(1);
        if (pop)     rptr_d = rptr_q + PW'(1);
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Set wins over clear so a dropped byte is never hidden.
        if (ovf_clr)              ovf_d = 1'b0;
        if (push_req && !push_ok) ovf_d = 1'b1;
        rd_hit_d  = !bus.mem_wr && (bus.mem_addr == STAT_ADDR);
        rd_data_d = rd_hit_d ? status : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wptr_q] <= bus.wr_data[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed and randomized bench for mmio_uart_tx; expected line/busy/status come
// from a frame-schedule model built from write times and queue occupancy.
module tb_mmio_uart_tx;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 8;
    localparam int FRAME   = 10 * CLK_DIV;
    localparam logic [9:0] DATA_A = 10'h001;
    localparam logic [9:0] STAT_A = 10'h002;
    localparam logic [9:0] IDLE_A = 10'h000;

    logic clk;
    logic rst;
    logic busy;
    logic uart_tx;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .DATA_ADDR  (DATA_A),
        .STAT_ADDR  (STAT_A)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .uart_tx (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int now   = 0;

    // Model: each accepted byte has a write edge and the edge its frame starts.
    int         fwrite[$];
    int         fstart[$];
    logic [7:0] fdata[$];
    logic       m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, now);
        end
    endtask

    function automatic logic exp_line(input int t);
        logic [7:0] b;
        int k;
        foreach (fstart[i]) begin
            if (t >= fstart[i] && t < fstart[i] + FRAME) begin
                k = (t - fstart[i]) / CLK_DIV;
                b = fdata[i];
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return b[k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int t);
        foreach (fstart[i])
            if (fwrite[i] <= t && fstart[i] + FRAME > t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_count(input int t);
        int c = 0;
        foreach (fstart[i])
            if (fwrite[i] <= t && fstart[i] > t) c++;
        return c;
    endfunction

    function automatic logic [15:0] exp_status(input int t);
        int c;
        c = exp_count(t);
        return {12'h000, (c == 0), m_ovf, (c == DEPTH), exp_busy(t)};
    endfunction

    // Accepted when fewer than DEPTH bytes remain unpopped after edge w.
    function automatic void model_push(input int w, input logic [7:0] d);
        int c = 0;
        int s;
        foreach (fstart[i])
            if (fstart[i] > w) c++;
        if (c < DEPTH) begin
            s = w + 1;
            if (fstart.size() > 0 && fstart[$] + FRAME > s) s = fstart[$] + FRAME;
            fwrite.push_back(w);
            fstart.push_back(s);
            fdata.push_back(d);
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        now++;
        #1;
        chk("tx_line", {15'h0, uart_tx}, {15'h0, exp_line(now)});
        chk("busy", {15'h0, busy}, {15'h0, exp_busy(now)});
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d);
        bus.mem_wr   = 1'b1;
        bus.mem_addr = a;
        bus.wr_data  = d;
        if (a == DATA_A) model_push(now + 1, d[7:0]);
        if (a == STAT_A && d[2]) m_ovf = 1'b0;
        tick();
        bus.mem_wr   = 1'b0;
        bus.mem_addr = IDLE_A;
        bus.wr_data  = 16'h0000;
    endtask

    task automatic rd_stat(input string tag, output logic [15:0] obs);
        logic [15:0] e;
        e = exp_status(now);
        bus.mem_wr   = 1'b0;
        bus.mem_addr = STAT_A;
        tick();
        obs = bus.rd_data;
        chk({tag, "_data"}, bus.rd_data, e);
        chk({tag, "_hit"}, {15'h0, bus.rd_hit}, 16'h0001);
        bus.mem_addr = IDLE_A;
        tick();
        chk({tag, "_hit_drop"}, {15'h0, bus.rd_hit}, 16'h0000);
        chk({tag, "_data_drop"}, bus.rd_data, 16'h0000);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, {15'h0, busy}, 16'h0000);
        repeat (3) tick();
    endtask

    initial begin
        logic [15:0] s;
        int nb;
        int r;
        logic [15:0] d;

        rst          = 1'b1;
        bus.mem_wr   = 1'b0;
        bus.mem_addr = IDLE_A;
        bus.wr_data  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        now = 0;

        chk("rst_tx", {15'h0, uart_tx}, 16'h0001);
        chk("rst_busy", {15'h0, busy}, 16'h0000);
        chk("rst_rd_data", bus.rd_data, 16'h0000);
        chk("rst_rd_hit", {15'h0, bus.rd_hit}, 16'h0000);
        rd_stat("rst_stat", s);
        chk("rst_stat_const", s, 16'h0008);

        // Single 'A' frame; start bit on the edge after the write.
        wr(DATA_A, 16'h0041);
        nb = 1;
        tick();
        chk("a_start_low", {15'h0, uart_tx}, 16'h0000);
        for (int i = 0; i < 60; i++) begin
            if (busy) nb++;
            tick();
        end
        chk("a_busy_len", 16'(nb), 16'd41);

        // Three back-to-back bytes.
        wr(DATA_A, 16'h0031);
        wr(DATA_A, 16'h0032);
        wr(DATA_A, 16'h0033);
        nb = 3;
        for (int i = 0; i < 140; i++) begin
            tick();
            if (busy) nb++;
        end
        chk("three_busy_len", 16'(nb), 16'd121);

        // Ten writes overflow an 8-deep FIFO by one byte.
        for (int i = 0; i < 10; i++) wr(DATA_A, 16'(i));
        rd_stat("ten_stat", s);
        chk("ten_stat_const", s, 16'h0007);
        wait_idle("ten_idle");

        wr(STAT_A, 16'h0004);
        rd_stat("clr_stat", s);
        chk("clr_ovf_bit", {15'h0, s[2]}, 16'h0000);
        chk("clr_idle_const", s, 16'h0008);

        // High byte of the write data is ignored.
        wr(DATA_A, 16'hAB55);
        wait_idle("ab55_idle");

        // Writes to an unrelated address must not enqueue.
        wr(10'h003, 16'h00FF);
        repeat (5) tick();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                repeat ($urandom_range(0, 60)) tick();
            end
            r = $urandom_range(0, 19);
            d = 16'($urandom);
            if (r < 15)       wr(DATA_A, d);
            else if (r < 17)  rd_stat("rand_stat", s);
            else if (r < 18)  wr(STAT_A, d);
            else if (r < 19)  wr(STAT_A, d | 16'h0004);
            else              wr(10'h003, d);
        end
        wait_idle("rand_idle");
        rd_stat("rand_end_stat", s);

        // Reset in the middle of a frame with three bytes still queued.
        wr(DATA_A, 16'h00C3);
        wr(DATA_A, 16'h005A);
        wr(DATA_A, 16'h0081);
        wr(DATA_A, 16'h00E7);
        repeat (12) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", {15'h0, uart_tx}, 16'h0001);
        chk("mid_rst_busy", {15'h0, busy}, 16'h0000);
        fwrite.delete();
        fstart.delete();
        fdata.delete();
        m_ovf = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rd_stat("post_rst_stat", s);
        chk("post_rst_stat_const", s, 16'h0008);
        nb = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!uart_tx) nb++;
        end
        chk("post_rst_quiet", 16'(nb), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
